// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one fulladder cell, LSB first, N cycles per operation.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ CIN;
  assign Cout = (A & B) | (CIN & (A ^ B));
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         Ovf
`endif
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sh, b_sh, s_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           s_bit, c_bit;
  logic           accept, last;

  fulladder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .CIN  (carry),
    .Sum  (s_bit),
    .Cout (c_bit)
  );

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: operands shift out LSB first, sum bits shift in from the MSB end.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= CIN;
      cnt   <= '0;
      s_sh  <= '0;
    end else if (state == RUN) begin
      a_sh  <= {1'b0, a_sh[N-1:1]};
      b_sh  <= {1'b0, b_sh[N-1:1]};
      s_sh  <= {s_bit, s_sh[N-1:1]};
      carry <= c_bit;
      cnt   <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final bit, so partial sums never leak out.
  always_ff @(posedge clk) begin
    if (reset) begin
      Sum  <= '0;
      Cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else if (last && !reset) begin
      Sum  <= {s_bit, s_sh[N-1:1]};
      Cout <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf  <= carry ^ c_bit;
`endif
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8): table vectors, random vectors, start collision and reset abort.
module tb_serial_adder;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset, start, CIN;
  logic [N-1:0] A, B;
  logic         busy, done;
  logic [N-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;
  res_t sb[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;
  vec_t vecs[8];

  logic [N-1:0] prev_sum;
  logic         prev_cout;

  always #5 clk = ~clk;

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one start pulse (sampled at the next edge E0) and push the expected result.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                       input logic [N-1:0] esum, input logic ecout, input logic eovf);
    res_t r;
    r.sum  = esum;
    r.cout = ecout;
    r.ovf  = eovf;
    sb.push_back(r);
    A = a; B = b; CIN = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); CIN = 1'($urandom);
  endtask

  task automatic issue_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    logic [N:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
    issue(a, b, cin, full[N-1:0], full[N], ovf);
  endtask

  // Called right after E0; optionally re-pulses start with 0xFF+0xFF so it is sampled at E0+repulse.
  task automatic wait_done(input string name, input int repulse);
    int   lat;
    res_t e;
    lat = 0;
    chk({name, "_busy0"}, busy, 1);
    for (int k = 1; k <= N + 4; k++) begin
      if (k == repulse) begin
        A = '1; B = '1; CIN = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      chk({name, "_busy"}, busy, 1);
      chk({name, "_hold_sum"}, Sum, prev_sum);
      chk({name, "_hold_cout"}, Cout, prev_cout);
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s_timeout done not seen within %0d cycles", name, N + 4);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard done with empty queue", name);
    end else begin
      chk({name, "_latency"}, lat, N);
      chk({name, "_busy_done"}, busy, 0);
      e = sb.pop_front();
      chk({name, "_sum"}, Sum, e.sum);
      chk({name, "_cout"}, Cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"}, Ovf, e.ovf);
`endif
      prev_sum  = e.sum;
      prev_cout = e.cout;
      @(posedge clk); #1;
      chk({name, "_strobe"}, done, 0);
      chk({name, "_idle"}, busy, 0);
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; CIN = 1'b0;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", Ovf, 0);
`endif
    prev_sum = '0; prev_cout = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      wait_done($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 4; i++) begin
      issue_model(N'($urandom), N'($urandom), 1'($urandom));
      wait_done($sformatf("rnd%0d", i), 0);
    end

    // start re-pulsed during RUN must be ignored
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    wait_done("repulse", 3);
    chk("repulse_no_second_busy", busy, 0);
    chk("repulse_queue_empty", sb.size(), 0);

    // reset at E0+4 aborts the operation
    A = 8'h5A; B = 8'h3C; CIN = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", Sum, 0);
    chk("abort_cout", Cout, 0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    prev_sum = '0; prev_cout = 1'b0;
    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    wait_done("after_abort", 0);

    // reset and start on the same edge: reset wins
    A = 8'h01; B = 8'h01; CIN = 1'b0; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1 start = 1'b0; reset = 1'b0;
    chk("rst_vs_start_busy", busy, 0);
    chk("rst_vs_start_sum", Sum, 0);

    chk("final_queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
